// File: rtl/fetch_pkg.sv
// fetch_pkg: types and constants shared by the instruction fetch unit and its
// prefetch buffer.
//   fetch_entry_t     one buffered fetch: byte address and the instruction word
//   INSTR_BYTES       PC increment per fetched instruction
//   DEFAULT_RESET_PC  default first fetch address after reset
package fetch_pkg;

  localparam int          INSTR_BYTES      = 4;
  localparam logic [63:0] DEFAULT_RESET_PC = 64'd0;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: prefetch buffer of fetch_entry_t between the fetch PC logic and
// decode. DEPTH must be a power of two so the pointers wrap naturally.
// Ports:
//   clk    in   clock
//   reset  in   synchronous active-high reset (empties the buffer)
//   push   in   write wdata at the tail (caller guarantees space or same-cycle pop)
//   pop    in   drop the head entry (caller guarantees count != 0)
//   flush  in   empty the buffer; overrides push/pop
//   wdata  in   entry to write
//   count  out  number of valid entries, 0..DEPTH
//   head   out  entry at the head (meaningless while count == 0)
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output logic [CW-1:0] count,
  output fetch_entry_t head
);

  fetch_entry_t mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the consumer only looks at head while count != 0.
  // When full with a simultaneous pop, wr_ptr == rd_ptr and overwriting the slot
  // is safe because the old head is consumed on the same edge.
  always_ff @(posedge clk) begin
    if (push && !flush && !reset) mem[wr_ptr] <= wdata;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC, addresses the combinational instruction ROM
// and buffers {pc, instruction} pairs toward decode with a valid/ready handshake.
// A redirect loads a new PC and flushes the buffer.
// Optional feature macro: FETCH_BOUNDS_CHECK_EN -- misaligned or out-of-range
// fetches set a sticky fetch_err and halt fetch until redirect or reset.
// Ports:
//   clk          in   clock
//   reset        in   synchronous active-high reset
//   imem_addr    out  byte address to ROM (the PC register)
//   imem_instr   in   instruction at imem_addr, combinational
//   redirect     in   load redirect_pc and flush the buffer
//   redirect_pc  in   new fetch address
//   dec_valid    out  head entry is valid
//   dec_ready    in   decode takes the head this cycle
//   dec_instr    out  head instruction (0 while empty)
//   dec_pc       out  head byte address (0 while empty)
//   fetch_err    out  sticky fetch error
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int          DEPTH     = 4,
  parameter int          MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [63:0] dec_pc,
  output logic        fetch_err
);

  localparam int CW = $clog2(DEPTH + 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("instr_fetch_unit: DEPTH must be a power of two >= 2");
  end
  if (MEM_BYTES < INSTR_BYTES || (MEM_BYTES & (MEM_BYTES - 1)) != 0) begin : g_bad_mem
    $error("instr_fetch_unit: MEM_BYTES must be a power of two >= 4");
  end

  logic [63:0]   pc_q;
  logic [CW-1:0] count;
  fetch_entry_t  head;
  fetch_entry_t  wdata;
  logic          pop;
  logic          push;
  logic          full;

  assign full      = (count == CW'(DEPTH));
  assign dec_valid = (count != '0);
  assign pop       = dec_valid & dec_ready;
  assign imem_addr = pc_q;
  assign dec_instr = dec_valid ? head.instr : '0;
  assign dec_pc    = dec_valid ? head.pc    : '0;
  assign wdata     = '{pc: pc_q, instr: imem_instr};

`ifdef FETCH_BOUNDS_CHECK_EN
  logic err_q;
  logic fetch_try;
  logic addr_bad;

  // 65-bit sum so a PC near 2^64 cannot wrap into range.
  assign addr_bad  = (pc_q[1:0] != 2'b00) ||
                     (({1'b0, pc_q} + 65'd3) >= 65'(MEM_BYTES));
  assign fetch_try = !redirect && !err_q;
  assign push      = fetch_try && !addr_bad && (!full || pop);
  assign fetch_err = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= RESET_PC;
      err_q <= 1'b0;
    end else if (redirect) begin
      pc_q  <= redirect_pc;
      err_q <= 1'b0;
    end else begin
      if (push)                  pc_q  <= pc_q + 64'(INSTR_BYTES);
      if (fetch_try && addr_bad) err_q <= 1'b1;
    end
  end
`else
  assign push      = !redirect && (!full || pop);
  assign fetch_err = 1'b0;

  always_ff @(posedge clk) begin
    if (reset)         pc_q <= RESET_PC;
    else if (redirect) pc_q <= redirect_pc;
    else if (push)     pc_q <= pc_q + 64'(INSTR_BYTES);
  end
`endif

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata (wdata),
    .count (count),
    .head  (head)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  localparam int          DEPTH     = 4;
  localparam int          MEM_BYTES = 1024;
  localparam logic [63:0] RESET_PC  = 64'd0;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [63:0] dec_pc;
  logic        fetch_err;

  int checks = 0;
  int errors = 0;

  instr_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .MEM_BYTES(MEM_BYTES)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_addr   (imem_addr),
    .imem_instr  (imem_instr),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .dec_valid   (dec_valid),
    .dec_ready   (dec_ready),
    .dec_instr   (dec_instr),
    .dec_pc      (dec_pc),
    .fetch_err   (fetch_err)
  );

  always #5 clk = ~clk;

  // Instruction ROM: every address yields a distinct pseudo-random word.
  function automatic logic [31:0] rom(input logic [63:0] a);
    return (a[31:0] * 32'd2654435761) ^ 32'hC0DE_0000 ^ a[63:32];
  endfunction

  always_comb imem_instr = rom(imem_addr);

  // Reference model: expected buffer contents (in order) and the expected PC.
  fetch_entry_t sb_q[$];
  logic [63:0]  m_pc;
  logic         m_err = 1'b0;
  logic         started = 1'b0;

  function automatic bit bad_addr(input logic [63:0] a);
`ifdef FETCH_BOUNDS_CHECK_EN
    return (a % 4 != 0) || (a > 64'(MEM_BYTES - 4));
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Model step for the cycle ending at this posedge. Any same-cycle pop was
  // already taken from sb_q by the monitor on the preceding negedge.
  task automatic model_update();
    if (reset) begin
      m_pc = RESET_PC;
      m_err = 1'b0;
      sb_q.delete();
    end else if (redirect) begin
      m_pc = redirect_pc;
      m_err = 1'b0;
      sb_q.delete();
    end else if (!m_err) begin
      if (bad_addr(m_pc)) m_err = 1'b1;
      else if (sb_q.size() < DEPTH) begin
        sb_q.push_back('{pc: m_pc, instr: rom(m_pc)});
        m_pc = m_pc + 64'd4;
      end
    end
  endtask

  // Monitor: compares presented outputs against the model, consumes on handshake.
  always @(negedge clk) begin
    if (started) begin
      check("imem_addr", imem_addr, m_pc);
      check("fetch_err", 64'(fetch_err), 64'(m_err));
      check("dec_valid", 64'(dec_valid), 64'(sb_q.size() != 0));
      if (sb_q.size() != 0) begin
        check("dec_pc", dec_pc, sb_q[0].pc);
        check("dec_instr", 64'(dec_instr), 64'(sb_q[0].instr));
        if (dec_ready && !reset) void'(sb_q.pop_front());
      end else begin
        check("dec_pc_empty", dec_pc, 64'd0);
        check("dec_instr_empty", 64'(dec_instr), 64'd0);
      end
    end
  end

  task automatic tick(input logic r, input logic rdir, input logic [63:0] rpc, input logic rdy);
    reset       = r;
    redirect    = rdir;
    redirect_pc = rpc;
    dec_ready   = rdy;
    @(posedge clk);
    model_update();
    started = 1'b1;
    #1;
  endtask

  initial begin
    logic [63:0] rpc;
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; dec_ready = 1'b1;
    // streaming after reset
    repeat (3) tick(1'b1, 1'b0, 64'd0, 1'b1);
    repeat (20) tick(1'b0, 1'b0, 64'd0, 1'b1);
    // stall, fill, drain; then reset to get a clean start for the stall case
    repeat (2) tick(1'b1, 1'b0, 64'd0, 1'b1);
    repeat (10) tick(1'b0, 1'b0, 64'd0, 1'b0);
    repeat (10) tick(1'b0, 1'b0, 64'd0, 1'b1);
    // redirect with entries queued
    repeat (3) tick(1'b0, 1'b0, 64'd0, 1'b0);
    tick(1'b0, 1'b1, 64'h40, 1'b0);
    repeat (8) tick(1'b0, 1'b0, 64'd0, 1'b1);
    // reset with buffer partially full
    repeat (2) tick(1'b0, 1'b0, 64'd0, 1'b0);
    tick(1'b1, 1'b0, 64'd0, 1'b1);
    repeat (5) tick(1'b0, 1'b0, 64'd0, 1'b1);
    // bounds cases
    tick(1'b0, 1'b1, 64'h3FE, 1'b1);
    repeat (4) tick(1'b0, 1'b0, 64'd0, 1'b1);
    tick(1'b0, 1'b1, 64'h400, 1'b1);
    repeat (4) tick(1'b0, 1'b0, 64'd0, 1'b1);
    tick(1'b0, 1'b1, 64'h3F4, 1'b0);
    repeat (6) tick(1'b0, 1'b0, 64'd0, 1'b1);
    tick(1'b0, 1'b1, 64'h0, 1'b1);
    repeat (6) tick(1'b0, 1'b0, 64'd0, 1'b1);
    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      case ($urandom_range(0, 3))
        0:       rpc = 64'($urandom_range(0, 255)) * 4;
        1:       rpc = 64'h3F0 + 64'($urandom_range(0, 20));
        2:       rpc = {32'd0, $urandom};
        default: rpc = {$urandom, $urandom};
      endcase
      tick($urandom_range(0, 63) == 0, $urandom_range(0, 11) == 0, rpc,
           $urandom_range(0, 3) != 0);
    end
    repeat (5) tick(1'b0, 1'b0, 64'd0, 1'b1);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
